integ_iter_scheduler: RTL and testbench

//  Top-level sequencer for the change-in-y integration loop. Runs a programmable number of

---
 rtl/integ_iter_scheduler_pkg.sv | 18 +
 rtl/integ_iter_scheduler_if.sv | 30 +++
 rtl/integ_iter_scheduler_watchdog.sv | 30 +++
 rtl/integ_iter_scheduler.sv | 132 +++++++++++++
 tb/tb_integ_iter_scheduler.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/integ_iter_scheduler_pkg.sv
// Shared types and default sizing for the change-in-y integration control slice.
package integ_ctrl_pkg;

  localparam int unsigned ITER_W_DEF      = 8;
  localparam int unsigned TIMEOUT_W_DEF   = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 255;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    COMMIT,
    NEXT,
    DONE,
    ERR
  } schedState_t;

endpackage

// File: rtl/integ_iter_scheduler_if.sv
// Handshake bundle between the module-level controller and the iteration scheduler.
interface integ_iter_scheduler_if
  import integ_ctrl_pkg::*;
#(
  parameter int unsigned ITER_W = ITER_W_DEF
);

  logic              in_enableEntireModule;
  logic [ITER_W-1:0] in_numIters;
  logic              in_accumCalcDoneFlag;
  logic              op_loadOperands;
  logic              op_enableAccumCalc;
  logic              op_commitY;
  logic [ITER_W-1:0] op_iterIndex;
  logic              op_allItersDoneFlag;
  logic              op_timeoutErr;

  modport master (
    output in_enableEntireModule, in_numIters, in_accumCalcDoneFlag,
    input  op_loadOperands, op_enableAccumCalc, op_commitY, op_iterIndex,
           op_allItersDoneFlag, op_timeoutErr
  );

  modport slave (
    input  in_enableEntireModule, in_numIters, in_accumCalcDoneFlag,
    output op_loadOperands, op_enableAccumCalc, op_commitY, op_iterIndex,
           op_allItersDoneFlag, op_timeoutErr
  );

endinterface

// File: rtl/integ_iter_scheduler_watchdog.sv
// CALC-phase watchdog: counts enabled cycles and flags expiry at TIMEOUT_CYC-1.
module integ_watchdog_timer #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TIMEOUT_W   = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_CYC - 1);

  logic [TIMEOUT_W-1:0] count;

  // Saturates at the limit so a stalled enable can never wrap back below it.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  always_comb begin
    expired = (count == LIMIT);
  end

endmodule

// File: rtl/integ_iter_scheduler.sv
// Iteration sequencer: load -> calc (watchdogged) -> commit, repeated for a latched count.
module integ_iter_scheduler
  import integ_ctrl_pkg::*;
#(
  parameter int unsigned ITER_W      = ITER_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned TIMEOUT_W   = TIMEOUT_W_DEF
) (
  input logic                   clock,
  input logic                   reset,
  integ_iter_scheduler_if.slave bus
);

  schedState_t       state;
  logic [ITER_W-1:0] numLatched;
  logic [ITER_W-1:0] iterIndex;
  logic              timerClear;
  logic              timerEnable;
  logic              timerExpired;

  always_comb begin
    timerClear  = (state == LOAD);
    timerEnable = (state == CALC);
  end

  integ_watchdog_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TIMEOUT_W   (TIMEOUT_W)
  ) watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (timerClear),
    .enable  (timerEnable),
    .expired (timerExpired)
  );

  // Outputs are set on the edge that enters the state they belong to, so they
  // are registered yet track the state exactly.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state                   <= IDLE;
      numLatched              <= '0;
      iterIndex               <= '0;
      bus.op_loadOperands     <= 1'b0;
      bus.op_enableAccumCalc  <= 1'b0;
      bus.op_commitY          <= 1'b0;
      bus.op_allItersDoneFlag <= 1'b0;
      bus.op_timeoutErr       <= 1'b0;
    end else begin
      bus.op_loadOperands     <= 1'b0;
      bus.op_enableAccumCalc  <= 1'b0;
      bus.op_commitY          <= 1'b0;
      bus.op_allItersDoneFlag <= 1'b0;
      bus.op_timeoutErr       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.in_enableEntireModule) begin
            numLatched <= bus.in_numIters;
            iterIndex  <= '0;
            if (bus.in_numIters == '0) begin
              state                   <= DONE;
              bus.op_allItersDoneFlag <= 1'b1;
            end else begin
              state               <= LOAD;
              bus.op_loadOperands <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (!bus.in_enableEntireModule) begin
            state <= IDLE;
          end else begin
            state                  <= CALC;
            bus.op_enableAccumCalc <= 1'b1;
          end
        end
        CALC: begin
          if (!bus.in_enableEntireModule) begin
            state <= IDLE;
          end else if (bus.in_accumCalcDoneFlag) begin
            state          <= COMMIT;
            bus.op_commitY <= 1'b1;
          end else if (timerExpired) begin
            state             <= ERR;
            bus.op_timeoutErr <= 1'b1;
          end else begin
            bus.op_enableAccumCalc <= 1'b1;
          end
        end
        COMMIT: begin
          if (!bus.in_enableEntireModule) begin
            state <= IDLE;
          end else if (iterIndex == numLatched - ITER_W'(1)) begin
            state                   <= DONE;
            bus.op_allItersDoneFlag <= 1'b1;
          end else begin
            state <= NEXT;
          end
        end
        NEXT: begin
          if (!bus.in_enableEntireModule) begin
            state <= IDLE;
          end else begin
            iterIndex           <= iterIndex + ITER_W'(1);
            state               <= LOAD;
            bus.op_loadOperands <= 1'b1;
          end
        end
        DONE: begin
          if (bus.in_enableEntireModule) begin
            bus.op_allItersDoneFlag <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        ERR: begin
          if (bus.in_enableEntireModule) begin
            bus.op_timeoutErr <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.op_iterIndex = iterIndex;
  end

endmodule

// File: tb/tb_integ_iter_scheduler.sv
// Randomized bench for integ_iter_scheduler against a per-run expected-timeline model.
module tb_integ_iter_scheduler;

  localparam int TO = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  integ_iter_scheduler_if #(.ITER_W(8)) bus ();

  integ_iter_scheduler #(
    .ITER_W      (8),
    .TIMEOUT_CYC (TO),
    .TIMEOUT_W   (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One entry per clock cycle of a run: what the outputs must show, and
  // whether the bench pulses done during that cycle.
  typedef struct {
    bit load;
    bit calc;
    bit commit;
    bit allDone;
    bit err;
    int idx;
    bit doneHere;
  } cycleExp_t;

  cycleExp_t tl[$];

  function automatic cycleExp_t mk(bit ld, bit ca, bit co, bit ad, bit er, int idx, bit dn);
    cycleExp_t e;
    e.load = ld; e.calc = ca; e.commit = co; e.allDone = ad; e.err = er;
    e.idx = idx; e.doneHere = dn;
    return e;
  endfunction

  // delays[it] = CALC cycle on which done arrives; anything above TO never arrives in time.
  function automatic void buildTimeline(int n, int delays[$]);
    tl.delete();
    if (n == 0) begin
      tl.push_back(mk(0, 0, 0, 1, 0, 0, 0));
      return;
    end
    for (int it = 0; it < n; it++) begin
      tl.push_back(mk(1, 0, 0, 0, 0, it, 0));
      if (delays[it] > TO) begin
        for (int c = 1; c <= TO; c++) tl.push_back(mk(0, 1, 0, 0, 0, it, 0));
        tl.push_back(mk(0, 0, 0, 0, 1, it, 0));
        return;
      end
      for (int c = 1; c <= delays[it]; c++) tl.push_back(mk(0, 1, 0, 0, 0, it, c == delays[it]));
      tl.push_back(mk(0, 0, 1, 0, 0, it, 0));
      if (it < n - 1) tl.push_back(mk(0, 0, 0, 0, 0, it, 0));
      else            tl.push_back(mk(0, 0, 0, 1, 0, it, 0));
    end
  endfunction

  function automatic int findCalc(int iter, int nth);
    int seen = 0;
    foreach (tl[p]) begin
      if (tl[p].calc && tl[p].idx == iter) begin
        seen++;
        if (seen == nth) return p;
      end
    end
    return tl.size() - 1;
  endfunction

  function automatic logic [31:0] flagsNow();
    return {27'd0, bus.op_loadOperands, bus.op_enableAccumCalc, bus.op_commitY,
            bus.op_allItersDoneFlag, bus.op_timeoutErr};
  endfunction

  function automatic logic [31:0] flagsExp(cycleExp_t e);
    return {27'd0, e.load, e.calc, e.commit, e.allDone, e.err};
  endfunction

  // Runs the prepared timeline from IDLE, leaving after entry stopAt by
  // dropping enable (or pulling reset), then checks the return to IDLE.
  task automatic runCase(input int n, input int stopAt, input bit useReset);
    cycleExp_t e;
    bus.in_numIters           = 8'(n);
    bus.in_enableEntireModule = 1'b1;
    bus.in_accumCalcDoneFlag  = 1'b0;
    for (int i = 0; i <= stopAt; i++) begin
      @(posedge clock); #1;
      e = tl[(i < tl.size()) ? i : tl.size() - 1];
      checkVal("flags", flagsNow(), flagsExp(e));
      checkVal("iterIndex", 32'(bus.op_iterIndex), 32'(e.idx));
      bus.in_numIters          = 8'($urandom);
      bus.in_accumCalcDoneFlag = e.doneHere | (!e.calc && ($urandom_range(0, 3) == 0));
    end
    if (useReset) begin
      reset = 1'b0;
      @(posedge clock); #1;
      checkVal("resetFlags", flagsNow(), 32'd0);
      checkVal("resetIndex", 32'(bus.op_iterIndex), 32'd0);
      reset = 1'b1;
    end
    bus.in_enableEntireModule = 1'b0;
    @(posedge clock); #1;
    checkVal("idleFlags", flagsNow(), 32'd0);
    bus.in_accumCalcDoneFlag = 1'b0;
  endtask

  initial begin
    int d[$];
    int n;
    int stopAt;
    reset                     = 1'b0;
    bus.in_enableEntireModule = 1'b0;
    bus.in_numIters           = '0;
    bus.in_accumCalcDoneFlag  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkVal("rstFlags", flagsNow(), 32'd0);
    checkVal("rstIndex", 32'(bus.op_iterIndex), 32'd0);
    reset = 1'b1;

    bus.in_accumCalcDoneFlag = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      checkVal("spuriousIdle", flagsNow(), 32'd0);
    end
    bus.in_accumCalcDoneFlag = 1'b0;

    d = '{10, 10, 10};
    buildTimeline(3, d);
    runCase(3, tl.size() + 3, 1'b0);

    d.delete();
    buildTimeline(0, d);
    runCase(0, 4, 1'b0);

    d = '{TO + 1};
    buildTimeline(1, d);
    runCase(1, tl.size() + 2, 1'b0);

    d = '{TO, 3};
    buildTimeline(2, d);
    runCase(2, tl.size() + 1, 1'b0);

    d = '{10, 10, 10};
    buildTimeline(3, d);
    runCase(3, findCalc(1, 5), 1'b0);
    d = '{4, 6};
    buildTimeline(2, d);
    runCase(2, tl.size() + 1, 1'b0);

    d = '{2, 30};
    buildTimeline(2, d);
    runCase(2, findCalc(1, 7), 1'b1);

    for (int k = 0; k < 30; k++) begin
      n = $urandom_range(0, 4);
      d.delete();
      for (int it = 0; it < n; it++) d.push_back($urandom_range(1, 20));
      buildTimeline(n, d);
      if ($urandom_range(0, 3) == 0) stopAt = $urandom_range(0, tl.size() - 1);
      else                            stopAt = tl.size() - 1 + $urandom_range(1, 3);
      runCase(n, stopAt, $urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
